// File: rtl/tick_bcd_pkg.sv
// Shared types and constants for the tick-driven BCD counter.
package tick_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}; codes 10..15 blank.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

endpackage

// File: rtl/tick_bcd_counter_bcd_digit.sv
// One BCD digit: combinational next value with carry/borrow in and out.
module bcd_digit
    import tick_bcd_pkg::*;
(
    input  bcd_t digit_in,
    input  logic en,
    input  logic up,
    output bcd_t digit_out,
    output logic co
);

    // Step the digit when enabled; out-of-range codes fold back into 0..9.
    always_comb begin
        digit_out = digit_in;
        co        = 1'b0;
        if (en) begin
            if (up) begin
                if (digit_in >= 4'd9) begin
                    digit_out = 4'd0;
                    co        = 1'b1;
                end else begin
                    digit_out = digit_in + 4'd1;
                end
            end else begin
                if (digit_in == 4'd0 || digit_in > 4'd9) begin
                    digit_out = 4'd9;
                    co        = (digit_in == 4'd0);
                end else begin
                    digit_out = digit_in - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/tick_bcd_counter.sv
// Tick-driven up/down BCD counter with IDLE/RUN/PAUSE control.
// Optional seven-segment scan outputs: define TICK_BCD_SEG_SCAN_EN.
module tick_bcd_counter
    import tick_bcd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_CYCLES = 100000
)
(
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    div_clk,
    input  logic                    start,
    input  logic                    hold,
    input  logic                    clear,
    input  logic                    up_dn,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    tick,
    output logic                    wrap,
    output logic                    running
`ifdef TICK_BCD_SEG_SCAN_EN
    ,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
`endif
);

    state_t                  state_q, state_d;
    logic                    div_q, div_d;
    logic                    armed_q, armed_d;
    logic                    tick_q, tick_d;
    logic                    wrap_q, wrap_d;
    logic [4*NUM_DIGITS-1:0] count_q, count_d;
    logic [4*NUM_DIGITS-1:0] count_step;
    logic [NUM_DIGITS:0]     chain;

    // Carry/borrow ripple; digit 0 always steps, so count_step is the next value.
    assign chain[0] = 1'b1;
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .digit_in  (count_q[4*g +: 4]),
            .en        (chain[g]),
            .up        (up_dn),
            .digit_out (count_step[4*g +: 4]),
            .co        (chain[g+1])
        );
    end

    // State register.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; dropping both start and hold returns to IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        if (!start && !hold) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (hold) state_d = PAUSE;
                PAUSE:   if (!hold && start) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        running = (state_q == RUN);
    end

    // Edge detect and count update; armed_q masks a div_clk already high at reset release.
    always_comb begin
        div_d   = div_clk;
        armed_d = 1'b1;
        tick_d  = div_clk & ~div_q & armed_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (tick_q && state_q == RUN) begin
            count_d = count_step;
            wrap_d  = chain[NUM_DIGITS];
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            div_q   <= 1'b0;
            armed_q <= 1'b0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            count_q <= '0;
        end else begin
            div_q   <= div_d;
            armed_q <= armed_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            count_q <= count_d;
        end
    end

    assign bcd  = count_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

`ifdef TICK_BCD_SEG_SCAN_EN
    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    bcd_t              digit_sel;

    // Dwell SCAN_CYCLES cycles on each digit, then move to the next.
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_W'(SCAN_CYCLES - 1)) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Scan registers.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
        end
    end

    // Decode the selected digit and drive its anode low.
    always_comb begin
        digit_sel = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) digit_sel = count_q[4*i +: 4];
        end
        seg = SEG_LUT[digit_sel];
        an  = ~(NUM_DIGITS'(1) << idx_q);
    end
`endif

endmodule
